fpu_input_register: RTL
=======================

Name: fpu_input_register

Overview:
Host-side operand/command register bank for the FPU, opposite end of the result/ready path.
- Host writes operand A, operand B and a control word, then rings a doorbell.
- The block freezes the operands, issues a one-cycle start pulse to the FPU core, and tracks the operation as busy until the core signals completion or a timeout expires.
- Provides status readback and sticky error flags for protocol violations.

Parameters:
TIMEOUT_CYCLES, 64, cycles in WAIT without fpu_done before abort; legal range 2..65535
TO_W, 16, width of timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  host write strobe, one write per cycle
wr_addr  input  3  write address (map below)
wr_data  input  32  write data
rd_en  input  1  host read strobe
rd_addr  input  3  read address
rd_data  output  32  read data, valid cycle after rd_en
fpu_done  input  1  one-cycle pulse from core: result captured
fpu_operand_a  output  32  operand A to core
fpu_operand_b  output  32  operand B to core
fpu_opcode  output  4  operation select
fpu_round_mode  output  3  rounding mode
fpu_int_en  output  1  interrupt enable passed to result side
fpu_start  output  1  one-cycle launch pulse
fpu_busy  output  1  operation in flight
fpu_err  output  1  OR of sticky error bits

Behaviour:
- Reset: all registers, rd_data, outputs = 0; state IDLE; counter 0. Reset mid-operation aborts silently: no start, no error.
- Address map. Reads of 5..7 return 0; writes to 5..7 are ignored.
  - 0 operand A (RW).
  - 1 operand B (RW).
  - 2 ctrl, RW: [3:0] opcode, [6:4] round_mode, [7] int_en, upper bits read 0.
  - 3 doorbell, W: bit0=1 launches, reads 0.
  - 4 status, R: {27'b0, timeout_err, wr_err, db_err, state[1:0]} with bits [4:2] = errors; W: write-1-to-clear on bits [4:2].
- FSM states IDLE=0, LAUNCH=1, WAIT=2.
  - IDLE: doorbell write with wr_data[0]=1 -> LAUNCH next cycle. A doorbell write with bit0=0 is a no-op.
  - LAUNCH: fpu_start=1 for exactly this cycle, counter cleared -> WAIT. fpu_done in LAUNCH -> IDLE directly.
  - WAIT: counter increments each cycle. fpu_done -> IDLE. Counter reaching TIMEOUT_CYCLES-1 without done -> IDLE, set timeout_err.
- Timing: doorbell accepted at edge N. fpu_start and fpu_busy are high in cycle N+1. fpu_busy = (state != IDLE), registered.
- Busy protection:
  - While busy, writes to addr 0..2 are dropped and set wr_err.
  - A doorbell while busy is dropped and sets db_err.
  - Operand/ctrl outputs are stable from LAUNCH until return to IDLE.
- fpu_done in IDLE is ignored, no error.
- Simultaneous events:
  - Doorbell write in the same cycle fpu_done returns the block to IDLE: state is still busy, so it is rejected with db_err.
  - W1C of an error bit in the same cycle that error is set: set wins.
- Read: rd_data registered, 1-cycle latency; holds its last value when rd_en=0. Status read reflects pre-edge state.
- fpu_err = timeout_err | wr_err | db_err, combinational from the sticky bits.

Test Plan:
- Reset then read all addresses 0..4 -> rd_data=0 each; fpu_start=0, fpu_busy=0.
- Write A=0x3F800000, B=0x40000000, ctrl=0x95, doorbell=1 at edge N -> cycle N+1: fpu_start=1, busy=1, operand_a=0x3F800000, opcode=5, round_mode=1, int_en=1. fpu_done at N+4 -> busy=0 at N+5, no errors.
- While busy, write A=0xDEADBEEF and a doorbell -> operand_a unchanged, no second start, status bits wr_err=1 and db_err=1, fpu_err=1. Write 0x0C to addr 4 -> both cleared, fpu_err=0.
- TIMEOUT_CYCLES=4, doorbell with no fpu_done -> busy for 5 cycles (1 LAUNCH + 4 WAIT), then IDLE with timeout_err=1; a later stray fpu_done is ignored.
- Doorbell write in the cycle fpu_done arrives in WAIT -> IDLE next cycle, no launch, db_err=1. A doorbell in the following cycle launches normally.
- Assert reset_n low during WAIT -> immediate busy=0 and all outputs 0. After release, a fresh doorbell launches with start one cycle later.

Source files
------------

// File: rtl/fpu_input_register_if.sv
// ---------------------------------------------------------------------------
// fpu_input_register_if
// Host register bus plus FPU launch/command signals for fpu_input_register.
//   Host write : wr_en, wr_addr[2:0], wr_data[31:0]
//   Host read  : rd_en, rd_addr[2:0], rd_data[31:0] (one-cycle latency)
//   Core side  : fpu_done (in), operands, opcode, round mode, int enable,
//                start pulse, busy and sticky-error summary (out)
// master = host/core environment, slave = the register bank.
// ---------------------------------------------------------------------------
interface fpu_input_register_if;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [2:0]  rd_addr;
   logic [31:0] rd_data;
   logic        fpu_done;
   logic [31:0] fpu_operand_a;
   logic [31:0] fpu_operand_b;
   logic [3:0]  fpu_opcode;
   logic [2:0]  fpu_round_mode;
   logic        fpu_int_en;
   logic        fpu_start;
   logic        fpu_busy;
   logic        fpu_err;

   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr, fpu_done,
      input  rd_data, fpu_operand_a, fpu_operand_b, fpu_opcode,
             fpu_round_mode, fpu_int_en, fpu_start, fpu_busy, fpu_err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr, fpu_done,
      output rd_data, fpu_operand_a, fpu_operand_b, fpu_opcode,
             fpu_round_mode, fpu_int_en, fpu_start, fpu_busy, fpu_err
   );
endinterface

// File: rtl/fpu_input_register.sv
// ---------------------------------------------------------------------------
// fpu_input_register
// Host-side operand/command register bank for the FPU core. The host loads
// operand A (addr 0), operand B (addr 1) and ctrl (addr 2), then rings the
// doorbell (addr 3, bit0). The bank freezes the operands, pulses fpu_start
// for one cycle and stays busy until fpu_done or a timeout. Status (addr 4)
// reports {timeout_err, wr_err, db_err, state}; error bits are sticky and
// write-1-to-clear.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : fpu_input_register_if.slave (host bus + core signals)
// Parameters:
//   TIMEOUT_CYCLES : WAIT cycles without fpu_done before abort (2..65535)
//   TO_W           : timeout counter width, 2^TO_W > TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module fpu_input_register #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TO_W           = 16
) (
   input logic                  clk,
   input logic                  reset_n,
   fpu_input_register_if.slave  bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]      state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic [31:0]     op_a_q, op_b_q;
   logic [7:0]      ctrl_q;
   logic            db_err_q, wr_err_q, to_err_q;
   logic [31:0]     rd_data_q;
   logic [31:0]     rd_mux;

   logic            busy;
   logic            reg_wr;
   logic            db_ring;
   logic            sts_wr;
   logic            timeout_hit;

   assign busy    = (state_q != ST_IDLE);
   assign reg_wr  = bus.wr_en && (bus.wr_addr <= 3'd2);
   assign db_ring = bus.wr_en && (bus.wr_addr == 3'd3) && bus.wr_data[0];
   assign sts_wr  = bus.wr_en && (bus.wr_addr == 3'd4);

   // fpu_done in the final WAIT cycle counts as completion, not a timeout
   assign timeout_hit = (state_q == ST_WAIT) && !bus.fpu_done && (cnt_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (db_ring) state_d = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            cnt_d   = '0;
            state_d = bus.fpu_done ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.fpu_done || timeout_hit) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Operand/ctrl registers only load while idle, which keeps the core's
   // inputs frozen from LAUNCH until the operation retires.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_a_q <= '0;
         op_b_q <= '0;
         ctrl_q <= '0;
      end else if (reg_wr && !busy) begin
         case (bus.wr_addr)
            3'd0:    op_a_q <= bus.wr_data;
            3'd1:    op_b_q <= bus.wr_data;
            default: ctrl_q <= bus.wr_data[7:0];
         endcase
      end
   end

   // Sticky errors: a set in the same cycle as its W1C clear wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_err_q <= 1'b0;
         wr_err_q <= 1'b0;
         to_err_q <= 1'b0;
      end else begin
         db_err_q <= (db_err_q && !(sts_wr && bus.wr_data[2])) || (db_ring && busy);
         wr_err_q <= (wr_err_q && !(sts_wr && bus.wr_data[3])) || (reg_wr && busy);
         to_err_q <= (to_err_q && !(sts_wr && bus.wr_data[4])) || timeout_hit;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (bus.rd_addr)
         3'd0:    rd_mux = op_a_q;
         3'd1:    rd_mux = op_b_q;
         3'd2:    rd_mux = {24'd0, ctrl_q};
         3'd4:    rd_mux = {27'd0, to_err_q, wr_err_q, db_err_q, state_q};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_q <= '0;
      end else if (bus.rd_en) begin
         rd_data_q <= rd_mux;
      end
   end

   assign bus.rd_data        = rd_data_q;
   assign bus.fpu_operand_a  = op_a_q;
   assign bus.fpu_operand_b  = op_b_q;
   assign bus.fpu_opcode     = ctrl_q[3:0];
   assign bus.fpu_round_mode = ctrl_q[6:4];
   assign bus.fpu_int_en     = ctrl_q[7];
   assign bus.fpu_start      = (state_q == ST_LAUNCH);
   assign bus.fpu_busy       = busy;
   assign bus.fpu_err        = to_err_q | wr_err_q | db_err_q;

endmodule
